// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation codes, FSM states and helpers for the EX-stage execute unit
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_XOR = 4'b0010,
        OP_ADD = 4'b0100,
        OP_SUB = 4'b0101,
        OP_BEQ = 4'b1000,
        OP_SLT = 4'b1001,
        OP_SLL = 4'b1100,
        OP_SRL = 4'b1101,
        OP_SRA = 4'b1110
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational single-bit shift step
// Ports:
//   op_i  shift kind (OP_SLL, OP_SRL, OP_SRA)
//   a_i   value to shift
//   y_o   value shifted by one bit
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int W = DEFAULT_DATA_WIDTH
) (
    input  alu_op_e        op_i,
    input  logic [W-1:0]   a_i,
    output logic [W-1:0]   y_o
);

    always_comb begin
        case (op_i)
            OP_SLL:  y_o = {a_i[W-2:0], 1'b0};
            OP_SRA:  y_o = {a_i[W-1], a_i[W-1:1]};
            default: y_o = {1'b0, a_i[W-1:1]};
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle EX-stage execute unit with valid/ready handshakes
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 kills any in-flight op, returns to IDLE
//   in_valid/in_ready     input handshake for Operation/SrcA/SrcB
//   Operation, SrcA, SrcB operation select and operands (low bits of SrcB = shift amount)
//   out_valid/out_ready   output handshake for ALUResult/Zero
//   ALUResult, Zero       registered result and its zero flag
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam int SW = $clog2(DATA_WIDTH);

    exec_state_e           state_q, state_d;
    alu_op_e               op_q, op_d;
    logic [SW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  zero_q, zero_d;

    alu_op_e               op_in;
    logic [SW-1:0]         shamt;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op_result;
    logic [DATA_WIDTH-1:0] step_y;

    assign op_in  = alu_op_e'(Operation);
    assign shamt  = SrcB[SW-1:0];
    assign accept = in_valid && (state_q == IDLE) && !flush;

    // res_q doubles as the shift accumulator, so no separate result copy is kept
    alu_shift_step #(.W(DATA_WIDTH)) u_step (
        .op_i (op_q),
        .a_i  (res_q),
        .y_o  (step_y)
    );

    // Single-cycle result; shifts load A here and iterate in SHIFT when shamt != 0
    always_comb begin
        case (op_in)
            OP_AND:  op_result = SrcA & SrcB;
            OP_OR:   op_result = SrcA | SrcB;
            OP_XOR:  op_result = SrcA ^ SrcB;
            OP_ADD:  op_result = SrcA + SrcB;
            OP_SUB:  op_result = SrcA - SrcB;
            OP_BEQ:  op_result = DATA_WIDTH'(SrcA == SrcB);
            OP_SLT:  op_result = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            OP_SLL,
            OP_SRL,
            OP_SRA:  op_result = SrcA;
            default: op_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d = (is_shift(op_in) && (shamt != '0)) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    if (cnt_q == SW'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign ALUResult = res_q;
    assign Zero      = zero_q;

    // Datapath next-state; result only moves on accept or while shifting
    always_comb begin
        op_d  = op_q;
        cnt_d = cnt_q;
        res_d = res_q;
        if (accept) begin
            op_d  = op_in;
            cnt_d = shamt;
            res_d = op_result;
        end else if ((state_q == SHIFT) && !flush) begin
            cnt_d = cnt_q - SW'(1);
            res_d = step_y;
        end
        zero_d = (res_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= OP_AND;
            cnt_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

endmodule
